// File: rtl/iir_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : iir_mult_sequencer
//  Purpose  : Operand sequencer for the single-precision multiplier of the
//             IIR notch filter. For every accepted sample it issues the five
//             biquad operand pairs (b0*x0, b1*x1, b2*x2, a1*y1, a2*y2) in
//             order, collects each result and forwards it with its tap index.
//             Owns the x delay line; y history and coefficients are inputs.
//             Operands and results pass through bit-exact.
//  Ports    : clk, rst_n           clock / async active-low reset
//             x_in/x_stb/x_ack     input sample handshake
//             b0,b1,b2,a1,a2       coefficients (a1/a2 pre-negated)
//             y1,y2                output history from the accumulator
//             clear                pulse: zero x history
//             mult_a/mult_b/mult_ab_stb/mult_ab_ack   operand handshake
//             mult_z/mult_z_stb/mult_z_ack            result handshake
//             prod_z/prod_idx/prod_stb/prod_ack       product handshake
//             busy                 high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module iir_mult_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x_in,
    input  logic        x_stb,
    output logic        x_ack,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic [31:0] b2,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] y1,
    input  logic [31:0] y2,
    input  logic        clear,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_ab_stb,
    input  logic        mult_ab_ack,
    input  logic [31:0] mult_z,
    input  logic        mult_z_stb,
    output logic        mult_z_ack,
    output logic [31:0] prod_z,
    output logic [2:0]  prod_idx,
    output logic        prod_stb,
    input  logic        prod_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT_Z = 3'd2,
        S_PUT_P  = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic [31:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [31:0] a1_q, a1_d, a2_q, a2_d;
    logic [31:0] y1_q, y1_d, y2_q, y2_d;
    logic        clear_pend_q, clear_pend_d;
    logic        x_ack_q, x_ack_d;
    logic        ab_stb_q, ab_stb_d;
    logic        z_ack_q, z_ack_d;
    logic        prod_stb_q, prod_stb_d;
    logic [31:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic [31:0] prod_z_q, prod_z_d;
    logic [2:0]  prod_idx_q, prod_idx_d;

    // Operand pair for the tap following idx_q, taken from the latched
    // sample context so the inputs may change once the sample is accepted.
    logic [31:0] nxt_a, nxt_b;

    always_comb begin
        nxt_a = b0_q;
        nxt_b = x0_q;
        case (idx_q)
            3'd0:    begin nxt_a = b1_q; nxt_b = x1_q; end
            3'd1:    begin nxt_a = b2_q; nxt_b = x2_q; end
            3'd2:    begin nxt_a = a1_q; nxt_b = y1_q; end
            3'd3:    begin nxt_a = a2_q; nxt_b = y2_q; end
            default: begin nxt_a = b0_q; nxt_b = x0_q; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        b2_d         = b2_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        clear_pend_d = clear_pend_q;
        x_ack_d      = x_ack_q;
        ab_stb_d     = ab_stb_q;
        z_ack_d      = z_ack_q;
        prod_stb_d   = prod_stb_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        prod_z_d     = prod_z_q;
        prod_idx_d   = prod_idx_q;

        case (state_q)
            S_IDLE: begin
                if (x_ack_q && x_stb) begin
                    x0_d     = x_in;
                    b0_d     = b0;
                    b1_d     = b1;
                    b2_d     = b2;
                    a1_d     = a1;
                    a2_d     = a2;
                    y1_d     = y1;
                    y2_d     = y2;
                    idx_d    = 3'd0;
                    x_ack_d  = 1'b0;
                    // First pair comes straight from the ports being latched.
                    ab_stb_d = 1'b1;
                    mult_a_d = b0;
                    mult_b_d = x_in;
                    state_d  = S_ISSUE;
                end else begin
                    x_ack_d  = 1'b1;
                end
                // Zeroing here also covers a clear coincident with an accept:
                // x1/x2 are only read from idx1 onward, after this edge.
                if (clear) begin
                    x1_d = 32'd0;
                    x2_d = 32'd0;
                end
            end

            S_ISSUE: begin
                if (ab_stb_q && mult_ab_ack) begin
                    ab_stb_d = 1'b0;
                    z_ack_d  = 1'b1;
                    state_d  = S_WAIT_Z;
                end
            end

            S_WAIT_Z: begin
                if (z_ack_q && mult_z_stb) begin
                    prod_z_d   = mult_z;
                    prod_idx_d = idx_q;
                    z_ack_d    = 1'b0;
                    prod_stb_d = 1'b1;
                    state_d    = S_PUT_P;
                end
            end

            S_PUT_P: begin
                if (prod_stb_q && prod_ack) begin
                    prod_stb_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_UPDATE;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        ab_stb_d = 1'b1;
                        mult_a_d = nxt_a;
                        mult_b_d = nxt_b;
                        state_d  = S_ISSUE;
                    end
                end
            end

            S_UPDATE: begin
                // A clear arriving in this very cycle is honoured immediately.
                if (clear_pend_q || clear) begin
                    x1_d = 32'd0;
                    x2_d = 32'd0;
                end else begin
                    x2_d = x1_q;
                    x1_d = x0_q;
                end
                clear_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Mid-sample clears are deferred so the current sample keeps its
        // history consistent across all five taps.
        if (clear && (state_q == S_ISSUE || state_q == S_WAIT_Z ||
                      state_q == S_PUT_P)) begin
            clear_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            x0_q         <= 32'd0;
            x1_q         <= 32'd0;
            x2_q         <= 32'd0;
            b0_q         <= 32'd0;
            b1_q         <= 32'd0;
            b2_q         <= 32'd0;
            a1_q         <= 32'd0;
            a2_q         <= 32'd0;
            y1_q         <= 32'd0;
            y2_q         <= 32'd0;
            clear_pend_q <= 1'b0;
            x_ack_q      <= 1'b0;
            ab_stb_q     <= 1'b0;
            z_ack_q      <= 1'b0;
            prod_stb_q   <= 1'b0;
            mult_a_q     <= 32'd0;
            mult_b_q     <= 32'd0;
            prod_z_q     <= 32'd0;
            prod_idx_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            b2_q         <= b2_d;
            a1_q         <= a1_d;
            a2_q         <= a2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            clear_pend_q <= clear_pend_d;
            x_ack_q      <= x_ack_d;
            ab_stb_q     <= ab_stb_d;
            z_ack_q      <= z_ack_d;
            prod_stb_q   <= prod_stb_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            prod_z_q     <= prod_z_d;
            prod_idx_q   <= prod_idx_d;
        end
    end

    assign x_ack       = x_ack_q;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign mult_ab_stb = ab_stb_q;
    assign mult_z_ack  = z_ack_q;
    assign prod_z      = prod_z_q;
    assign prod_idx    = prod_idx_q;
    assign prod_stb    = prod_stb_q;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
